// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and control-word layout for the sequenced 9-bit ISA decoder.
// Field widths in ctrl_word_t are the natural instruction slices; the top resizes to its parameters.
package ctrl_pkg;

  localparam logic [2:0] OP_MEM   = 3'b010;
  localparam logic [2:0] OP_SET   = 3'b011;
  localparam logic [2:0] OP_MVIN  = 3'b100;
  localparam logic [2:0] OP_MVOUT = 3'b101;
  localparam logic [2:0] OP_BR    = 3'b110;

  localparam logic [1:0] SUB_PLAIN = 2'b00;
  localparam logic [1:0] SUB_INPL  = 2'b01;
  localparam logic [1:0] SUB_LOAD  = 2'b10;
  localparam logic [1:0] SUB_STORE = 2'b11;

  localparam logic [1:0] BR_NE = 2'b00;
  localparam logic [1:0] BR_EQ = 2'b01;
  localparam logic [1:0] BR_GT = 2'b10;
  localparam logic [1:0] BR_LT = 2'b11;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  typedef struct packed {
    logic       branch_en;
    logic       mem_read;
    logic       mem_write;
    logic       imm;
    logic       reg_write;
    logic       inplace;
    logic       move;
    logic       halt;
    logic [3:0] reg_sel;
    logic [3:0] move_from;
    logic [5:0] targ_sel;
  } ctrl_word_t;

  function automatic logic branch_taken(input logic [1:0] cond, input flags_t f);
    logic taken;
    case (cond)
      BR_NE:   taken = !f.eq;
      BR_EQ:   taken = f.eq;
      BR_GT:   taken = f.gt;
      default: taken = f.lt;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-side handshake plus datapath-side control outputs of ctrl_seq.
// master drives instructions, flags and memory acknowledge; slave is the sequencer.
interface ctrl_seq_if #(
  parameter int TARG_W    = 6,
  parameter int REG_SEL_W = 4
);

  logic                 InstrValid;
  logic [8:0]           Instruction;
  logic                 InstrReady;
  logic                 FlagWe;
  logic                 Eq;
  logic                 Gt;
  logic                 Lt;
  logic                 MemAck;
  logic                 OutValid;
  logic                 BranchEn;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 Imm;
  logic                 RegWrite;
  logic                 Inplace;
  logic                 Move;
  logic [REG_SEL_W-1:0] RegSel;
  logic [REG_SEL_W-1:0] MoveFrom;
  logic [TARG_W-1:0]    TargSel;
  logic                 Halted;
  logic                 MemErr;

  modport master (
    output InstrValid, Instruction, FlagWe, Eq, Gt, Lt, MemAck,
    input  InstrReady, OutValid, BranchEn, MemRead, MemWrite, Imm, RegWrite,
           Inplace, Move, RegSel, MoveFrom, TargSel, Halted, MemErr
  );

  modport slave (
    input  InstrValid, Instruction, FlagWe, Eq, Gt, Lt, MemAck,
    output InstrReady, OutValid, BranchEn, MemRead, MemWrite, Imm, RegWrite,
           Inplace, Move, RegSel, MoveFrom, TargSel, Halted, MemErr
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction word plus effective compare flags to control word.
// Halt is matched on the full word before any opcode decode.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [8:0] instr,
  input  flags_t     flags,
  output ctrl_word_t word
);

  logic [2:0] op;
  logic [1:0] sub;

  assign op  = instr[8:6];
  assign sub = instr[5:4];

  always_comb begin
    word           = '0;
    word.reg_write = 1'b1;
    word.reg_sel   = instr[3:0];
    if (instr == HALT_INSTR) begin
      word.reg_write = 1'b0;
      word.halt      = 1'b1;
    end else begin
      case (op)
        OP_MEM: begin
          case (sub)
            SUB_LOAD:  word.mem_read = 1'b1;
            SUB_STORE: begin
              word.mem_write = 1'b1;
              word.reg_write = 1'b0;
            end
            SUB_INPL:  word.inplace = 1'b1;
            default:   word.reg_write = 1'b1;
          endcase
        end
        OP_SET: begin
          word.imm     = 1'b1;
          word.reg_sel = 4'd0;
        end
        OP_MVIN: begin
          word.move      = 1'b1;
          word.reg_sel   = {3'b000, instr[1]};
          word.move_from = instr[5:2];
        end
        OP_MVOUT: begin
          word.move      = 1'b1;
          word.move_from = {3'b000, instr[5]};
        end
        OP_BR: begin
          // Branches never write the register file, taken or not.
          word.reg_write = 1'b0;
          if (branch_taken(sub, flags)) begin
            word.branch_en = 1'b1;
            word.targ_sel  = instr[5:0];
          end
        end
        default: word.reg_write = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control decoder: accepts one instruction per RUN cycle, registers its control word with a 1-cycle OutValid,
// stalls load/store until MemAck (timeout -> sticky MemErr/Halted). CTRL_SEQ_PERF_CNT_EN adds retire/branch counters.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int TARG_W      = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_SEL_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  ctrl_seq_if.slave  bus
`ifdef CTRL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] RetireCnt,
  output logic [31:0] BranchTakenCnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t               state;
  flags_t               flag_q;
  flags_t               flags_in;
  flags_t               flags_eff;
  ctrl_word_t           word;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 ready_q;
  logic                 accept;

  logic                 out_vld_q;
  logic                 branch_en_q;
  logic                 imm_q;
  logic                 reg_write_q;
  logic                 inplace_q;
  logic                 move_q;
  logic [REG_SEL_W-1:0] reg_sel_q;
  logic [REG_SEL_W-1:0] move_from_q;
  logic [TARG_W-1:0]    targ_sel_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic                 halted_q;
  logic                 mem_err_q;

  assign flags_in  = '{eq: bus.Eq, gt: bus.Gt, lt: bus.Lt};
  // Branches see this cycle's compare result when the flag write coincides with them.
  assign flags_eff = bus.FlagWe ? flags_in : flag_q;
  assign accept    = bus.InstrValid && ready_q;

  ctrl_decode u_decode (
    .instr (bus.Instruction),
    .flags (flags_eff),
    .word  (word)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= RUN;
      ready_q     <= 1'b0;
      flag_q      <= '0;
      tmo_cnt     <= '0;
      out_vld_q   <= 1'b0;
      branch_en_q <= 1'b0;
      imm_q       <= 1'b0;
      reg_write_q <= 1'b0;
      inplace_q   <= 1'b0;
      move_q      <= 1'b0;
      reg_sel_q   <= '0;
      move_from_q <= '0;
      targ_sel_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      if (bus.FlagWe) flag_q <= flags_in;

      out_vld_q   <= accept;
      branch_en_q <= accept && word.branch_en;
      imm_q       <= accept && word.imm;
      reg_write_q <= accept && word.reg_write;
      inplace_q   <= accept && word.inplace;
      move_q      <= accept && word.move;
      reg_sel_q   <= accept ? REG_SEL_W'(word.reg_sel) : '0;
      move_from_q <= accept ? REG_SEL_W'(word.move_from) : '0;
      targ_sel_q  <= accept ? word.targ_sel[TARG_W-1:0] : '0;

      case (state)
        RUN: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (word.halt) begin
              state    <= HALTED;
              ready_q  <= 1'b0;
              halted_q <= 1'b1;
            end else if (word.mem_read || word.mem_write) begin
              state       <= MEM_WAIT;
              ready_q     <= 1'b0;
              tmo_cnt     <= '0;
              mem_read_q  <= word.mem_read;
              mem_write_q <= word.mem_write;
            end
          end
        end
        MEM_WAIT: begin
          // An acknowledge on the final wait cycle still completes the access.
          if (bus.MemAck) begin
            state       <= RUN;
            ready_q     <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= HALTED;
            halted_q    <= 1'b1;
            mem_err_q   <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        HALTED: ready_q <= 1'b0;
        default: begin
          state   <= HALTED;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstrReady = ready_q;
  assign bus.OutValid   = out_vld_q;
  assign bus.BranchEn   = branch_en_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.Imm        = imm_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.Inplace    = inplace_q;
  assign bus.Move       = move_q;
  assign bus.RegSel     = reg_sel_q;
  assign bus.MoveFrom   = move_from_q;
  assign bus.TargSel    = targ_sel_q;
  assign bus.Halted     = halted_q;
  assign bus.MemErr     = mem_err_q;

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] br_taken_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retire_cnt   <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (accept && (retire_cnt != 32'hFFFF_FFFF)) retire_cnt <= retire_cnt + 32'd1;
      if (accept && word.branch_en && (br_taken_cnt != 32'hFFFF_FFFF))
        br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end

  assign RetireCnt      = retire_cnt;
  assign BranchTakenCnt = br_taken_cnt;
`endif

endmodule
